mem_responder: RTL and testbench

Unified instruction/data memory responder for the multicycle MIPS datapath. It is the target side of the memory strobes issued by the Control FSM: it accepts one MemRead or MemWrite request at a time, inserts a fixed number of wait states, and then returns a single-cycle MemReady pulse. On reads it also returns MemData, which feeds the IR/MDR path. The Control FSM holds its memory state until MemReady is seen.

---
 rtl/mem_responder.sv | 118 +++++++++++
 tb/tb_mem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Unified instruction/data memory target for the multicycle MIPS datapath.
// Accepts one MemRead/MemWrite request, waits WAIT_STATES cycles, then pulses MemReady.
module mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] MemData,
  output logic        MemReady,
  output logic        MemBusy,
  output logic        MemErr
);

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [3:0]              r_cnt;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [31:0]             r_wdata;
  logic                    r_wr;
  logic                    r_err;
  logic [31:0]             r_mem_data;
  logic [31:0]             r_ram [DEPTH];

  logic                    w_any_req;
  logic                    w_bad_req;
  logic                    w_access;
  logic                    w_acc_wr;
  logic [ADDR_WIDTH-1:0]   w_acc_idx;
  logic [31:0]             w_acc_wdata;
  logic                    w_unused;

  // Address bits above the word index are ignored, so addresses alias modulo depth.
  assign w_unused  = &{1'b0, Addr[31:ADDR_WIDTH+2]};

  assign w_any_req = MemRead | MemWrite;
  assign w_bad_req = w_any_req & ((MemRead & MemWrite) | (Addr[1:0] != 2'b00));

  // With no wait states the access happens on the capture edge, straight from the inputs.
  assign w_access    = ((r_state == ST_IDLE) && w_any_req && !w_bad_req && (WAIT_STATES == 0))
                    || ((r_state == ST_WAIT) && (r_cnt == 4'd0));
  assign w_acc_wr    = (r_state == ST_IDLE) ? MemWrite              : r_wr;
  assign w_acc_idx   = (r_state == ST_IDLE) ? Addr[ADDR_WIDTH+1:2]  : r_idx;
  assign w_acc_wdata = (r_state == ST_IDLE) ? WriteData             : r_wdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          if (w_bad_req || (WAIT_STATES == 0)) w_next_state = ST_RESP;
          else                                  w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: if (r_cnt == 4'd0) w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    MemReady = (r_state == ST_RESP);
    MemBusy  = (r_state != ST_IDLE);
    MemErr   = (r_state == ST_RESP) && r_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_any_req) begin
      r_cnt   <= CNT_LOAD;
      r_idx   <= Addr[ADDR_WIDTH+1:2];
      r_wdata <= WriteData;
      r_wr    <= MemWrite;
      r_err   <= w_bad_req;
    end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Read data only moves on a successful read; writes and errors leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_mem_data <= 32'd0;
    else if (w_access && !w_acc_wr) r_mem_data <= r_ram[w_acc_idx];
  end

  // NOTE: the RAM array has no reset; contents survive rst_n and it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (w_access && w_acc_wr) r_ram[w_acc_idx] <= w_acc_wdata;
  end

  assign MemData = r_mem_data;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, reset and
// zero-wait-state sequences, then random traffic against a word-array model.
module tb_mem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [31:0] Addr, WriteData, MemData;
  logic        MemReady, MemBusy, MemErr;

  logic        z_rd, z_wr;
  logic [31:0] z_addr, z_wd, z_data;
  logic        z_ready, z_busy, z_err;

  int n_checks = 0;
  int n_errs   = 0;

  logic [31:0] m_mem [256];
  logic [31:0] m_last;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [13];

  mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .MemData(MemData),
    .MemReady(MemReady), .MemBusy(MemBusy), .MemErr(MemErr)
  );

  mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .MemRead(z_rd), .MemWrite(z_wr),
    .Addr(z_addr), .WriteData(z_wd), .MemData(z_data),
    .MemReady(z_ready), .MemBusy(z_busy), .MemErr(z_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd256);
  endfunction

  // Model: error on misalignment or both strobes; otherwise access the word array.
  task automatic model(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       output logic exp_err, output int exp_lat);
    exp_err = (rd && wr) || (a % 4 != 0);
    exp_lat = exp_err ? 1 : WS + 1;
    if (!exp_err && wr) m_mem[m_idx(a)] = wd;
    if (!exp_err && rd) m_last = m_mem[m_idx(a)];
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge one cycle after RESP.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic err, output logic [31:0] data);
    bit got = 0;
    lat = 0; err = 1'bx; data = 'x;
    MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd;
    while (!got && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (MemReady) begin
        got = 1; err = MemErr; data = MemData;
        MemRead = 0; MemWrite = 0;
      end else begin
        check("busy_in_wait", {31'd0, MemBusy}, 32'd1);
        check("err_without_ready", {31'd0, MemErr}, 32'd0);
      end
    end
    MemRead = 0; MemWrite = 0;
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); @(negedge clk);
    check("ready_one_cycle", {30'd0, MemReady, MemBusy}, 32'd0);
  endtask

  initial begin
    int          lat, exp_lat;
    logic        err, exp_err;
    logic [31:0] data, a, wd;

    rst_n = 0; MemRead = 0; MemWrite = 0; Addr = 0; WriteData = 0;
    z_rd = 0; z_wr = 0; z_addr = 0; z_wd = 0;
    m_last = 32'd0;
    foreach (m_mem[i]) m_mem[i] = 'x;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'h11,  32'h0,        1'b1, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 1'b1, 32'h20,  32'h55AA00FF, 1'b0, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b1, 32'h20,  32'hFFFFFFFF, 1'b1, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 32'h55AA00FF};
    vecs[7]  = '{1'b0, 1'b1, 32'h0,   32'h00001234, 1'b0, 32'h55AA00FF};
    vecs[8]  = '{1'b1, 1'b0, 32'h400, 32'h0,        1'b0, 32'h00001234};
    vecs[9]  = '{1'b0, 1'b1, 32'h8,   32'h0BADF00D, 1'b0, 32'h00001234};
    vecs[10] = '{1'b1, 1'b0, 32'h8,   32'h0,        1'b0, 32'h0BADF00D};
    vecs[11] = '{1'b0, 1'b1, 32'h13,  32'h00000001, 1'b1, 32'h0BADF00D};
    vecs[12] = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};

    #1;
    check("reset_data", MemData, 32'd0);
    check("reset_flags", {29'd0, MemReady, MemBusy, MemErr}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Directed vectors: fixed expectations, with latency from the wait-state rule.
    for (int i = 0; i < 13; i++) begin
      model(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, exp_err, exp_lat);
      txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, err, data);
      check($sformatf("vec%0d_latency", i), lat, exp_lat);
      check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
    end

    // Reset during WAIT of a write: outputs clear at once and the write is dropped.
    MemWrite = 1; Addr = 32'h8; WriteData = 32'hA5A5A5A5;
    @(posedge clk); #1;
    check("pre_abort_busy", {31'd0, MemBusy}, 32'd1);
    rst_n = 0; #1;
    check("abort_data", MemData, 32'd0);
    check("abort_flags", {29'd0, MemReady, MemBusy, MemErr}, 32'd0);
    MemWrite = 0;
    m_last = 32'd0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    model(1'b1, 1'b0, 32'h8, 32'h0, exp_err, exp_lat);
    txn(1'b1, 1'b0, 32'h8, 32'h0, lat, err, data);
    check("abort_read_latency", lat, exp_lat);
    check("abort_read_data", data, 32'h0BADF00D);

    // Zero wait states with a strobe held high: RESP every other cycle.
    z_wr = 1; z_addr = 32'h4; z_wd = 32'hC0FFEE00;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("ws0_ready_%0d", k), {31'd0, z_ready}, k % 2);
      check($sformatf("ws0_busy_%0d", k), {31'd0, z_busy}, k % 2);
      check($sformatf("ws0_err_%0d", k), {31'd0, z_err}, 32'd0);
    end
    z_wr = 0;
    @(negedge clk);
    z_rd = 1;
    @(posedge clk); @(negedge clk);
    z_rd = 0;
    check("ws0_read_ready", {31'd0, z_ready}, 32'd1);
    check("ws0_read_data", z_data, 32'hC0FFEE00);
    @(negedge clk);

    // Fill words 0..15 so random reads always hit known data.
    for (int w = 0; w < 16; w++) begin
      a = w * 4; wd = $urandom;
      model(1'b0, 1'b1, a, wd, exp_err, exp_lat);
      txn(1'b0, 1'b1, a, wd, lat, err, data);
      check("fill_err", {31'd0, err}, 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      int   kind;
      logic rd, wr;
      kind = $urandom_range(0, 9);
      a    = $urandom_range(0, 3) * 1024 + $urandom_range(0, 15) * 4;
      wd   = $urandom;
      rd   = (kind < 5) || (kind == 8) || (kind == 9 && wd[0]);
      wr   = (kind >= 5 && kind <= 8) || (kind == 9 && !wd[0]);
      if (kind == 9) a = a + $urandom_range(1, 3);
      model(rd, wr, a, wd, exp_err, exp_lat);
      txn(rd, wr, a, wd, lat, err, data);
      check($sformatf("rand%0d_latency", i), lat, exp_lat);
      check($sformatf("rand%0d_err", i), {31'd0, err}, {31'd0, exp_err});
      check($sformatf("rand%0d_data", i), data, m_last);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
